// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel: the fetch unit drives req/addr,
// memory answers with ack/rdata.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus a req/ack instruction fetcher feeding decode.
// An illegal next PC parks the unit in a terminal error state until reset.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       npc_in,
  input  logic              advance,
  pc_fetch_unit_if.master   imem,
  output logic [31:0]       pc,
  output logic [31:0]       pc_4,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              addr_err,
  output logic [31:0]       fetch_cnt
);

  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(IMEM_WORDS) * 32'd4 - 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] cnt_nxt;
  logic        npc_legal;

  assign npc_legal = (npc_in[1:0] == 2'b00) &&
                     (npc_in >= IMEM_BASE)  &&
                     (npc_in <= IMEM_LAST);

  // advance only matters in S_VALID and ack only in S_REQ; elsewhere both are ignored
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    cnt_nxt   = fetch_cnt;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem.imem_ack) begin
          instr_nxt = imem.imem_rdata;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (advance) begin
          pc_nxt    = npc_in;
          cnt_nxt   = fetch_cnt + 32'd1;
          state_nxt = npc_legal ? S_REQ : S_ERR;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      instr     <= 32'd0;
      fetch_cnt <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr     <= instr_nxt;
      fetch_cnt <= cnt_nxt;
    end
  end

  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == S_VALID);
  assign addr_err       = (state == S_ERR);
  assign pc_4           = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a vector table for the main fetch flow
// plus hand-written reset/error sequences.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] npc_in;
  logic        advance;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if imem ();

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .npc_in      (npc_in),
    .advance     (advance),
    .imem        (imem.master),
    .pc          (pc),
    .pc_4        (pc_4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .addr_err    (addr_err),
    .fetch_cnt   (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        adv;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic adv, input logic [31:0] npc, input logic ack,
                         input logic [31:0] rdata, input logic e_req, input logic e_valid,
                         input logic e_err, input logic [31:0] e_pc, input logic [31:0] e_pc4,
                         input logic [31:0] e_instr, input logic [31:0] e_cnt);
    vec_t v;
    v.adv = adv; v.npc = npc; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_valid = e_valid; v.e_err = e_err;
    v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic e_req, input logic e_valid,
                              input logic e_err, input logic [31:0] e_pc,
                              input logic [31:0] e_pc4, input logic [31:0] e_instr,
                              input logic [31:0] e_cnt);
    check32({tag, ".imem_req"},    {31'd0, imem.imem_req}, {31'd0, e_req});
    check32({tag, ".instr_valid"}, {31'd0, instr_valid},   {31'd0, e_valid});
    check32({tag, ".addr_err"},    {31'd0, addr_err},      {31'd0, e_err});
    check32({tag, ".pc"},          pc,                     e_pc);
    check32({tag, ".imem_addr"},   imem.imem_addr,         e_pc);
    check32({tag, ".pc_4"},        pc_4,                   e_pc4);
    check32({tag, ".instr"},       instr,                  e_instr);
    check32({tag, ".fetch_cnt"},   fetch_cnt,              e_cnt);
  endtask

  // drive one cycle of inputs at a falling edge, return at the next falling edge
  task automatic apply_stimulus(input logic adv, input logic [31:0] npc,
                                input logic ack, input logic [31:0] rdata);
    advance         = adv;
    npc_in          = npc;
    imem.imem_ack   = ack;
    imem.imem_rdata = rdata;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    reset           = 1'b1;
    advance         = 1'b0;
    npc_in          = 32'd0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check_output(tag, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h0000_3004, 32'd0, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    advance         = 1'b0;
    npc_in          = 32'd0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;

    //      adv npc            ack rdata          req val err pc             pc4            instr          cnt
    add_vec(0, 32'h0,          0, 32'h0,          1, 0, 0, 32'h0000_3000, 32'h0000_3004, 32'h0,          0);
    add_vec(0, 32'h0,          1, 32'h3C01_1234,  0, 1, 0, 32'h0000_3000, 32'h0000_3004, 32'h3C01_1234,  0);
    add_vec(1, 32'h0000_3004,  0, 32'h0,          1, 0, 0, 32'h0000_3004, 32'h0000_3008, 32'h3C01_1234,  1);
    add_vec(0, 32'h0,          0, 32'hAAAA_0000,  1, 0, 0, 32'h0000_3004, 32'h0000_3008, 32'h3C01_1234,  1);
    add_vec(0, 32'h0,          0, 32'hAAAA_0000,  1, 0, 0, 32'h0000_3004, 32'h0000_3008, 32'h3C01_1234,  1);
    add_vec(0, 32'h0,          1, 32'h1111_0001,  0, 1, 0, 32'h0000_3004, 32'h0000_3008, 32'h1111_0001,  1);
    add_vec(1, 32'h0000_3008,  0, 32'h0,          1, 0, 0, 32'h0000_3008, 32'h0000_300C, 32'h1111_0001,  2);
    add_vec(0, 32'h0,          0, 32'h0,          1, 0, 0, 32'h0000_3008, 32'h0000_300C, 32'h1111_0001,  2);
    add_vec(0, 32'h0,          0, 32'h0,          1, 0, 0, 32'h0000_3008, 32'h0000_300C, 32'h1111_0001,  2);
    add_vec(0, 32'h0,          1, 32'h2222_0002,  0, 1, 0, 32'h0000_3008, 32'h0000_300C, 32'h2222_0002,  2);
    add_vec(1, 32'h0000_300C,  0, 32'h0,          1, 0, 0, 32'h0000_300C, 32'h0000_3010, 32'h2222_0002,  3);
    add_vec(0, 32'h0,          0, 32'h0,          1, 0, 0, 32'h0000_300C, 32'h0000_3010, 32'h2222_0002,  3);
    add_vec(0, 32'h0,          0, 32'h0,          1, 0, 0, 32'h0000_300C, 32'h0000_3010, 32'h2222_0002,  3);
    add_vec(0, 32'h0,          1, 32'h3333_0003,  0, 1, 0, 32'h0000_300C, 32'h0000_3010, 32'h3333_0003,  3);
    // ack while valid is ignored
    add_vec(0, 32'h0,          1, 32'hDEAD_BEEF,  0, 1, 0, 32'h0000_300C, 32'h0000_3010, 32'h3333_0003,  3);
    add_vec(1, 32'h0000_3010,  0, 32'h0,          1, 0, 0, 32'h0000_3010, 32'h0000_3014, 32'h3333_0003,  4);
    // advance while requesting is ignored
    add_vec(1, 32'h0000_3080,  0, 32'h0,          1, 0, 0, 32'h0000_3010, 32'h0000_3014, 32'h3333_0003,  4);
    add_vec(1, 32'h0000_3090,  1, 32'h4444_0004,  0, 1, 0, 32'h0000_3010, 32'h0000_3014, 32'h4444_0004,  4);
    // redirect
    add_vec(1, 32'h0000_3040,  0, 32'h0,          1, 0, 0, 32'h0000_3040, 32'h0000_3044, 32'h4444_0004,  5);
    add_vec(0, 32'h0,          1, 32'h5555_0005,  0, 1, 0, 32'h0000_3040, 32'h0000_3044, 32'h5555_0005,  5);
    // last legal word
    add_vec(1, 32'h0000_3FFC,  0, 32'h0,          1, 0, 0, 32'h0000_3FFC, 32'h0000_4000, 32'h5555_0005,  6);
    add_vec(0, 32'h0,          1, 32'h6666_0006,  0, 1, 0, 32'h0000_3FFC, 32'h0000_4000, 32'h6666_0006,  6);
    // misaligned -> terminal error, then five ignored advance/ack pulses
    add_vec(1, 32'h0000_3002,  0, 32'h0,          0, 0, 1, 32'h0000_3002, 32'h0000_3006, 32'h6666_0006,  7);
    for (int k = 0; k < 5; k++)
      add_vec(1, 32'h0000_3004,  1, 32'h7777_0000,  0, 0, 1, 32'h0000_3002, 32'h0000_3006, 32'h6666_0006,  7);

    do_reset("reset0");
    for (int i = 0; i < vq.size(); i++) begin
      apply_stimulus(vq[i].adv, vq[i].npc, vq[i].ack, vq[i].rdata);
      check_output($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_valid, vq[i].e_err,
                   vq[i].e_pc, vq[i].e_pc4, vq[i].e_instr, vq[i].e_cnt);
    end

    // below base
    do_reset("reset1");
    apply_stimulus(0, 32'h0, 0, 32'h0);
    apply_stimulus(0, 32'h0, 1, 32'h0BAD_0001);
    apply_stimulus(1, 32'h0000_2FFC, 0, 32'h0);
    check_output("below_base", 0, 0, 1, 32'h0000_2FFC, 32'h0000_3000, 32'h0BAD_0001, 1);

    // one word past the end
    do_reset("reset2");
    apply_stimulus(0, 32'h0, 0, 32'h0);
    apply_stimulus(0, 32'h0, 1, 32'h0BAD_0002);
    apply_stimulus(1, 32'h0000_4000, 0, 32'h0);
    check_output("past_end", 0, 0, 1, 32'h0000_4000, 32'h0000_4004, 32'h0BAD_0002, 1);

    // top of address space: pc_4 wraps to zero
    do_reset("reset3");
    apply_stimulus(0, 32'h0, 0, 32'h0);
    apply_stimulus(0, 32'h0, 1, 32'h0BAD_0003);
    apply_stimulus(1, 32'hFFFF_FFFC, 0, 32'h0);
    check_output("wrap", 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0BAD_0003, 1);

    // reset while waiting for ack at 0x3008, then a late ack after release
    do_reset("reset4");
    apply_stimulus(0, 32'h0, 0, 32'h0);
    apply_stimulus(0, 32'h0, 1, 32'h1000_0001);
    apply_stimulus(1, 32'h0000_3004, 0, 32'h0);
    apply_stimulus(0, 32'h0, 1, 32'h1000_0002);
    apply_stimulus(1, 32'h0000_3008, 0, 32'h0);
    check_output("mid_pre", 1, 0, 0, 32'h0000_3008, 32'h0000_300C, 32'h1000_0002, 2);
    advance = 1'b0;
    reset   = 1'b1;
    #1;
    check_output("mid_async", 0, 0, 0, 32'h0000_3000, 32'h0000_3004, 32'd0, 0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(0, 32'h0, 1, 32'h2000_0003);
    check_output("mid_release", 1, 0, 0, 32'h0000_3000, 32'h0000_3004, 32'd0, 0);
    apply_stimulus(0, 32'h0, 1, 32'h2000_0003);
    check_output("mid_refetch", 0, 1, 0, 32'h0000_3000, 32'h0000_3004, 32'h2000_0003, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential consumer of the next-PC value produced by the core's next-PC logic.
- Holds the architectural PC register and fetches the instruction at PC from instruction memory over a req/ack handshake.
- Presents the instruction to decode with a valid flag, and loads the new PC when the core advances.
- Sits between the next-PC logic, the instruction memory and the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 1024, number of 32-bit words in instruction memory. Legal range is IMEM_BASE to IMEM_BASE+4*IMEM_WORDS-4.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- npc_in  input  32  next PC from the next-PC logic; sampled only on an accepted advance.
- advance  input  1  core has consumed the current instruction; load npc_in.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- imem_ack  input  1  memory has returned data on imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- pc  output  32  current PC register.
- pc_4  output  32  pc + 4, combinational, wraps modulo 2^32.
- instr  output  32  registered instruction at pc.
- instr_valid  output  1  instr corresponds to pc and may be consumed.
- addr_err  output  1  sticky flag: illegal fetch address was loaded.
- fetch_cnt  output  32  number of accepted advances since reset; wraps modulo 2^32.

Behaviour:
- One clock; reset is asynchronous and active-high. While reset is high:
  - pc = RESET_PC, instr = 0, fetch_cnt = 0.
  - state = S_IDLE, so imem_req = 0, instr_valid = 0, addr_err = 0.
- States:
  - S_IDLE: outputs idle; the first clock edge after reset deasserts moves to S_REQ.
  - S_REQ: imem_req = 1 and imem_addr = pc, both held stable until imem_ack. On a clock edge with imem_ack = 1: instr <= imem_rdata, go to S_VALID.
  - S_VALID: instr_valid = 1; instr and pc are held.
    - On an edge with advance = 1: pc <= npc_in and fetch_cnt <= fetch_cnt + 1.
    - If npc_in is legal, go to S_REQ; otherwise go to S_ERR.
  - S_ERR: addr_err = 1, imem_req = 0, instr_valid = 0. Terminal until reset; advance and imem_ack are ignored.
- Legal address: npc_in[1:0] == 2'b00, npc_in >= IMEM_BASE, and npc_in <= IMEM_BASE + 4*IMEM_WORDS - 4.
- RESET_PC is trusted and is not checked.
- Latency:
  - Reset release to imem_req high: 1 cycle.
  - imem_ack edge to instr_valid high: next cycle.
  - advance edge to imem_req high with the new address: next cycle.
  - Zero-wait-state memory (ack in the first S_REQ cycle) gives one instruction every 2 cycles.
- advance outside S_VALID is ignored: no pc change and no count.
- imem_ack outside S_REQ is ignored: instr is unchanged.
- advance and imem_ack asserted together: only the one relevant to the current state takes effect.
- No in-flight cancellation. A redirect (branch/jump) is just a different npc_in on advance.
- Reset asserted mid-handshake (S_REQ waiting for ack): immediate return to reset values. A late ack after release is ignored because the block is in S_IDLE.
- pc wrap: npc_in = 32'hFFFF_FFFC gives pc_4 = 0. That address is illegal under the defaults, so the block enters S_ERR.

Test Plan:
- Reset then ack in first S_REQ cycle with rdata=32'h3C01_1234:
  - imem_req rises 1 cycle after release with imem_addr=32'h0000_3000.
  - Next cycle instr=32'h3C01_1234, instr_valid=1, pc_4=32'h0000_3004.
- Sequential run: advance with npc_in=pc_4 for 3 instructions, memory with 2 wait states:
  - pc steps 3000→3004→3008→300C.
  - imem_addr is stable while ack is low.
  - fetch_cnt=3.
- Redirect: in S_VALID at pc=32'h0000_3010, advance with npc_in=32'h0000_3040 → next request at 32'h0000_3040; no fetch of 32'h0000_3014.
- Errors:
  - advance with npc_in=32'h0000_3002 → addr_err=1 next cycle, imem_req=0, instr_valid=0; stays set through 5 further advance/ack pulses.
  - npc_in=32'h0000_2FFC (below base) → addr_err=1.
  - npc_in=32'h0000_3FFC (last legal word) → fetch issued normally.
- Ignored inputs: advance pulsed while in S_REQ, and imem_ack pulsed while in S_VALID → pc, instr and fetch_cnt all unchanged.
- Reset mid-handshake: assert reset while imem_req=1 at pc=32'h0000_3008, then ack in the first cycle after release:
  - pc=32'h0000_3000, instr=0, instr_valid=0.
  - Subsequent fetch is from 32'h0000_3000.
